// File: rtl/sm4_pkg.sv
// SM4 shared constants and helpers: FK/CK, S-box, L and L' transforms, FSM state encoding.
// Shared by the iterative decryptor and the encryptor.
package sm4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } sm4_state_t;

    localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

    localparam logic [31:0] CK [32] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    function automatic logic [7:0] sbox8(input logic [7:0] a);
        return SBOX[a];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] sm4_l(input logic [31:0] b);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] sm4_lprime(input logic [31:0] b);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

endpackage

// File: rtl/sm4_tau.sv
// SM4 non-linear layer: four parallel S-boxes on a 32-bit word, purely combinational.
module sm4_tau
    import sm4_pkg::*;
(
    input  logic [31:0] a,
    output logic [31:0] b
);

    assign b = {sbox8(a[31:24]), sbox8(a[23:16]), sbox8(a[15:8]), sbox8(a[7:0])};

endmodule

// File: rtl/sm4_decrypt_iter.sv
// Iterative SM4 decryptor: on-chip key expansion then 32 rounds with rk31..rk0, UNROLL steps per clock.
// Optional build macro SM4_DEC_KEY_CACHE_EN skips key expansion when mk repeats the last expanded key.
//
//   state     | meaning
//   ST_IDLE   | in_ready high, waiting for a job
//   ST_KEYEXP | expanding round keys into the rk file
//   ST_ROUND  | applying rounds with keys in reverse order
//   ST_DONE   | register plain, hold out_valid until accepted
module sm4_decrypt_iter
    import sm4_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] mk,
    input  logic [127:0] cipher,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain,
    output logic         busy
);

    localparam int         SHIFT = (UNROLL == 4) ? 2 : (UNROLL == 2) ? 1 : 0;
    localparam logic [4:0] LAST  = 5'((32 / UNROLL) - 1);

    sm4_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] x0, x1, x2, x3;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] rk_file [32];
    logic [31:0] nxt0, nxt1, nxt2, nxt3;
    logic [31:0] step_rk  [UNROLL];
    logic [4:0]  step_idx [UNROLL];
    logic        phase_key;
    logic        last_step;
    logic [4:0]  base;

`ifdef SM4_DEC_KEY_CACHE_EN
    logic [127:0] cache_mk;
    logic         cache_vld;
    logic         cache_hit;
    assign cache_hit = cache_vld && (mk == cache_mk);
`endif

    assign phase_key = (state == ST_KEYEXP);
    assign last_step = (cnt == LAST);
    assign base      = cnt << SHIFT;

    // One tau per unrolled step, shared by key expansion and rounds; each step slides the 4-word window.
    for (genvar j = 0; j < UNROLL; j++) begin : g_step
        logic [31:0] w0, w1, w2, w3, t_in, t_out, nw;
        if (j == 0) begin : g_first
            assign w0 = phase_key ? k0 : x0;
            assign w1 = phase_key ? k1 : x1;
            assign w2 = phase_key ? k2 : x2;
            assign w3 = phase_key ? k3 : x3;
        end else begin : g_next
            assign w0 = g_step[j-1].w1;
            assign w1 = g_step[j-1].w2;
            assign w2 = g_step[j-1].w3;
            assign w3 = g_step[j-1].nw;
        end
        assign step_idx[j] = base + 5'(j);
        assign t_in = w1 ^ w2 ^ w3 ^ (phase_key ? CK[step_idx[j]] : rk_file[~step_idx[j]]);
        sm4_tau u_tau (.a(t_in), .b(t_out));
        assign nw = w0 ^ (phase_key ? sm4_lprime(t_out) : sm4_l(t_out));
        assign step_rk[j] = nw;
    end

    assign nxt0 = g_step[UNROLL-1].w1;
    assign nxt1 = g_step[UNROLL-1].w2;
    assign nxt2 = g_step[UNROLL-1].w3;
    assign nxt3 = g_step[UNROLL-1].nw;

    always_ff @(posedge clk) begin
        if (phase_key) begin
            for (int j = 0; j < UNROLL; j++) begin
                rk_file[step_idx[j]] <= step_rk[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            {x0, x1, x2, x3} <= '0;
            {k0, k1, k2, k3} <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            plain     <= '0;
            busy      <= 1'b0;
`ifdef SM4_DEC_KEY_CACHE_EN
            cache_mk  <= '0;
            cache_vld <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        {x0, x1, x2, x3} <= cipher;
                        {k0, k1, k2, k3} <= mk ^ {FK[0], FK[1], FK[2], FK[3]};
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef SM4_DEC_KEY_CACHE_EN
                        if (cache_hit) begin
                            state <= ST_ROUND;
                        end else begin
                            state     <= ST_KEYEXP;
                            cache_mk  <= mk;
                            cache_vld <= 1'b0;
                        end
`else
                        state <= ST_KEYEXP;
`endif
                    end
                end
                ST_KEYEXP: begin
                    {k0, k1, k2, k3} <= {nxt0, nxt1, nxt2, nxt3};
                    cnt <= last_step ? 5'd0 : cnt + 5'd1;
                    if (last_step) begin
                        state <= ST_ROUND;
`ifdef SM4_DEC_KEY_CACHE_EN
                        cache_vld <= 1'b1;
`endif
                    end
                end
                ST_ROUND: begin
                    {x0, x1, x2, x3} <= {nxt0, nxt1, nxt2, nxt3};
                    cnt <= last_step ? 5'd0 : cnt + 5'd1;
                    if (last_step) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        plain     <= {x3, x2, x1, x0};
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_decrypt_iter.sv
// Directed bench for sm4_decrypt_iter: standard vector, backpressure, reset abort, key cache, unroll, round trip.
module tb_sm4_decrypt_iter;
    import sm4_pkg::*;

    localparam logic [127:0] MK1 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT1 = 128'h681edf34d206965e86b3e94f536e4246;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] mk, cipher, plain;
    logic         in_valid2, in_ready2, out_valid2, busy2;
    logic         in_valid4, in_ready4, out_valid4, busy4;
    logic [127:0] plain2, plain4;

    int           n_cmp = 0;
    int           n_err = 0;
    logic         mc_valid;
    logic [127:0] mc_mk;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sm4_decrypt_iter #(.UNROLL(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mk(mk), .cipher(cipher),
        .out_valid(out_valid), .out_ready(out_ready), .plain(plain), .busy(busy));

    sm4_decrypt_iter #(.UNROLL(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .mk(mk), .cipher(cipher),
        .out_valid(out_valid2), .out_ready(1'b1), .plain(plain2), .busy(busy2));

    sm4_decrypt_iter #(.UNROLL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .mk(mk), .cipher(cipher),
        .out_valid(out_valid4), .out_ready(1'b1), .plain(plain4), .busy(busy4));

    function automatic logic [31:0] rot32(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] tau_m(input logic [31:0] a);
        return {sbox8(a[31:24]), sbox8(a[23:16]), sbox8(a[15:8]), sbox8(a[7:0])};
    endfunction

    // Reference encryptor: forward key schedule with CK generated arithmetically.
    function automatic logic [127:0] enc_model(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0] k [36];
        logic [31:0] x [36];
        logic [31:0] ck, t;
        k[0] = key[127:96] ^ 32'ha3b1bac6;
        k[1] = key[95:64]  ^ 32'h56aa3350;
        k[2] = key[63:32]  ^ 32'h677d9197;
        k[3] = key[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
            t = tau_m(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ t ^ rot32(t, 13) ^ rot32(t, 23);
        end
        x[0] = pt[127:96]; x[1] = pt[95:64]; x[2] = pt[63:32]; x[3] = pt[31:0];
        for (int i = 0; i < 32; i++) begin
            t = tau_m(x[i+1] ^ x[i+2] ^ x[i+3] ^ k[i+4]);
            x[i+4] = x[i] ^ t ^ rot32(t, 2) ^ rot32(t, 10) ^ rot32(t, 18) ^ rot32(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic int model_lat(input logic [127:0] key);
`ifdef SM4_DEC_KEY_CACHE_EN
        if (mc_valid && key == mc_mk) return 33;
`endif
        return 65;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mc_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Called #1 after a rising edge. Runs one job end to end.
    task automatic run_job(input logic [127:0] k_in, input logic [127:0] c_in, input logic [127:0] p_exp,
                           input int hold, input bit noise, input string tag);
        int lat;
        int exp_l;
        int wc;
        bit rdy_bad;
        exp_l = model_lat(k_in);
        wc = 0;
        while (in_ready !== 1'b1 && wc < 20) begin
            @(posedge clk); #1;
            wc++;
        end
        check({tag, " in_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        mk = k_in;
        cipher = c_in;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mk = {$urandom, $urandom, $urandom, $urandom};
        cipher = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        rdy_bad = 1'b0;
        while (lat < 150) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid === 1'b1) break;
            if (in_ready !== 1'b0) rdy_bad = 1'b1;
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                mk = {$urandom, $urandom, $urandom, $urandom};
                cipher = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 128'(lat), 128'(exp_l));
        check({tag, " plain"}, plain, p_exp);
        check({tag, " in_ready low while busy"}, 128'(rdy_bad), 128'(0));
`ifdef SM4_DEC_KEY_CACHE_EN
        mc_valid = 1'b1;
        mc_mk = k_in;
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " held plain"}, plain, p_exp);
            check({tag, " held out_valid"}, 128'(out_valid), 128'(1));
            check({tag, " held in_ready"}, 128'(in_ready), 128'(0));
        end
        if (out_valid === 1'b1) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check({tag, " out_valid after handshake"}, 128'(out_valid), 128'(0));
            check({tag, " in_ready after handshake"}, 128'(in_ready), 128'(1));
            check({tag, " busy after handshake"}, 128'(busy), 128'(0));
        end
    endtask

    initial begin
        logic [127:0] pt, ct, key;
        int lat2, lat4;
        logic [127:0] p2, p4;

        rst_n = 1'b0;
        in_valid = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0;
        out_ready = 1'b0;
        mk = '0; cipher = '0;
        mc_valid = 1'b0; mc_mk = '0;

        repeat (3) @(posedge clk); #1;
        check("reset in_ready", 128'(in_ready), 128'(0));
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset plain", plain, 128'(0));
        check("reset busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset", 128'(in_ready), 128'(1));

        // Unroll 2 and 4 on the standard vector
        mk = MK1; cipher = CT1;
        in_valid2 = 1'b1; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0; in_valid4 = 1'b0;
        lat2 = 0; lat4 = 0; p2 = '0; p4 = '0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (out_valid2 === 1'b1 && lat2 == 0) begin lat2 = c; p2 = plain2; end
            if (out_valid4 === 1'b1 && lat4 == 0) begin lat4 = c; p4 = plain4; end
            if (lat2 != 0 && lat4 != 0) break;
        end
        check("unroll2 latency", 128'(lat2), 128'(33));
        check("unroll2 plain", p2, MK1);
        check("unroll4 latency", 128'(lat4), 128'(17));
        check("unroll4 plain", p4, MK1);

        run_job(MK1, CT1, MK1, 0, 1'b0, "vec1");
        run_job(MK1, CT1, MK1, 10, 1'b0, "backpressure");

        // Abort in the middle of a job
        in_valid = 1'b1; mk = MK1; cipher = CT1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("busy mid job", 128'(busy), 128'(1));
        rst_n = 1'b0;
        mc_valid = 1'b0;
        #1;
        check("abort out_valid", 128'(out_valid), 128'(0));
        check("abort busy", 128'(busy), 128'(0));
        check("abort in_ready", 128'(in_ready), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(MK1, CT1, MK1, 0, 1'b0, "after abort");

        // Key cache sequence: repeat key, then flipped key
        do_reset();
        run_job(MK1, CT1, MK1, 0, 1'b0, "cache first");
        pt = 128'h00112233445566778899aabbccddeeff;
        run_job(MK1, enc_model(MK1, pt), pt, 0, 1'b0, "cache repeat");
        key = MK1 ^ 128'd1;
        run_job(key, enc_model(key, pt), pt, 0, 1'b0, "cache flipped");

        // Round trip with ignored in_valid pulses while busy
        for (int n = 0; n < 200; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            ct  = enc_model(key, pt);
            run_job(key, ct, pt, 0, 1'b1, "roundtrip");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
